// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture buffer for the single-cycle MIPS core: arm/trigger-controlled
// recording of retired instructions into a circular buffer, drained via valid/ready.
module cpu_trace_buffer #(
  parameter int DEPTH = 64,
  parameter int TS_W  = 16,
  parameter int REC_W = TS_W + 102
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   commit_valid,
  input  logic [31:0]            commit_pc,
  input  logic [31:0]            commit_inst,
  input  logic                   rf_we,
  input  logic [4:0]             rf_waddr,
  input  logic [31:0]            rf_wdata,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [31:0]            trig_pc,
  input  logic                   circ_mode,
  input  logic                   filter_we,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [REC_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic                   overflow,
  output logic [15:0]            dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t            st, st_nxt;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt, cnt_nxt;
  logic [TS_W-1:0]   ts;
  logic              ovf;
  logic [15:0]       drop;
  logic              full, qual, trig_hit, pop, push, blocked, wr_en, overwrite, lose;

  assign full     = (cnt == FULL_CNT);
  assign qual     = commit_valid && (!filter_we || (rf_we && rf_waddr != 5'd0));
  assign trig_hit = commit_valid && (commit_pc == trig_pc);
  assign pop      = (cnt != '0) && rd_ready;

  always_ff @(posedge clk_in) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    push      = 1'b0;
    lose      = 1'b0;
    blocked   = 1'b0;
    wr_en     = 1'b0;
    overwrite = 1'b0;
    cnt_nxt   = cnt;
    if (arm) begin
      st_nxt = trig_en ? S_ARMED : S_CAPTURE;
    end else begin
      unique case (st)
        S_ARMED: begin
          // stop beats a same-cycle trigger: the session ends without recording
          if (stop) st_nxt = S_DONE;
          else if (trig_hit) begin
            st_nxt = S_CAPTURE;
            push   = qual;
          end
        end
        S_CAPTURE: begin
          push = qual;
          if (stop) st_nxt = S_DONE;
        end
        S_DONE:  lose = qual && !circ_mode;
        default: ;
      endcase
      // full in stop mode with no room being freed: the commit is lost
      blocked   = push && full && !pop && !circ_mode;
      wr_en     = push && !blocked;
      overwrite = wr_en && full && !pop;
      if (wr_en && !pop && !full) cnt_nxt = cnt + 1'b1;
      else if (pop && !wr_en)     cnt_nxt = cnt - 1'b1;
      if (blocked) begin
        lose   = 1'b1;
        st_nxt = S_DONE;
      end
      if (wr_en && !circ_mode && cnt_nxt == FULL_CNT) st_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset || arm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drop   <= '0;
      ts     <= '0;
    end else begin
      if (wr_en)            wr_ptr <= wr_ptr + 1'b1;
      if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
      if (overwrite)              ovf  <= 1'b1;
      if (lose && drop != 16'hFFFF) drop <= drop + 1'b1;
      // the trigger cycle itself is ts=0, so capture proper starts at 1
      if (st == S_ARMED && st_nxt == S_CAPTURE) ts <= TS_W'(1);
      else if (st == S_CAPTURE && ts != '1)     ts <= ts + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset && wr_en)
      mem[wr_ptr] <= {ts, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata};
  end

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (cnt != '0);
  assign count    = cnt;
  assign state    = st;
  assign overflow = ovf;
  assign dropped  = drop;
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable commit-trace capture buffer for the single-cycle MIPS CPU.
- Records per-instruction commit information (pc, instruction, register-file write) into an on-chip circular buffer. Recording starts on arm and an optional PC trigger.
- Records are drained through a valid/ready read port by a debug/UART bridge.
- Replaces per-cycle simulation dumps with a parametrised hardware trace that works on the board.

Parameters:
DEPTH, 64, number of record slots; power of 2, minimum 4.
TS_W, 16, width of the relative cycle timestamp stored per record.
REC_W, TS_W+102, record width (derived; do not override).

Ports:
clk_in  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
commit_valid  input  1  CPU retires an instruction this cycle.
commit_pc  input  32  PC of the retiring instruction.
commit_inst  input  32  instruction word.
rf_we  input  1  register-file write enable of the retiring instruction.
rf_waddr  input  5  destination register.
rf_wdata  input  32  write data.
arm  input  1  one-cycle pulse: clear buffer and start a capture session.
stop  input  1  one-cycle pulse: end capture.
trig_en  input  1  1 = wait for trig_pc before capturing; 0 = capture immediately.
trig_pc  input  32  trigger PC.
circ_mode  input  1  1 = circular overwrite when full; 0 = stop when full.
filter_we  input  1  1 = record only commits with rf_we=1 and rf_waddr!=0.
rd_ready  input  1  consumer accepts rd_data.
rd_valid  output  1  buffer non-empty.
rd_data  output  REC_W  oldest record, {ts, pc, inst, we, waddr, wdata}, MSB to LSB.
count  output  clog2(DEPTH)+1  records held.
state  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
overflow  output  1  sticky: a record was overwritten in circular mode.
dropped  output  16  saturating count of qualifying commits lost in stop mode.

Behaviour:
- Reset values: state IDLE, pointers 0, count 0, overflow 0, dropped 0, timestamp 0, rd_valid 0. rd_data is don't-care while rd_valid=0.
- Reset mid-operation aborts everything immediately; memory contents are not cleared.
- A commit qualifies when commit_valid=1 and (filter_we=0, or rf_we=1 with rf_waddr!=0).
- Arm, from any state: pointers, count, overflow, dropped and timestamp cleared next edge.
  - Next state ARMED if trig_en=1, else CAPTURE.
  - arm takes priority over stop and over the same-cycle commit; that commit is not recorded.
- ARMED:
  - A commit with commit_valid=1 and commit_pc==trig_pc moves state to CAPTURE.
  - That commit is recorded with ts=0 if it qualifies.
  - Other commits are ignored.
  - stop moves state to DONE.
- CAPTURE:
  - Timestamp is 0 on the first CAPTURE cycle, +1 per cycle after, saturates at all-ones.
  - The trigger commit, or the first commit after arm when trig_en=0, gets ts=0.
  - Each qualifying commit writes one record at wr_ptr; wr_ptr then increments mod DEPTH.
  - stop moves state to DONE next edge; a commit in the stop cycle is still recorded.
- Full handling:
  - Stop mode (circ_mode=0): when count reaches DEPTH, state becomes DONE on the same edge as the filling write. Qualifying commits in DONE increment dropped (saturating at 0xFFFF).
  - Circular mode, full, push without pop: overwrite the oldest record, rd_ptr advances, count stays DEPTH, overflow sets.
  - Circular mode, full, push with pop: normal pop and push, count stays DEPTH, overflow unchanged.
- Read port:
  - First-word-fall-through: rd_data = mem[rd_ptr]; rd_valid = (count!=0).
  - Pop occurs when rd_valid and rd_ready; rd_ptr increments mod DEPTH.
  - Reads are allowed in every state.
  - Push and pop in the same cycle when not full leaves count unchanged.
  - A pop when empty is ignored.
- DONE: only arm leaves DONE. Commits are not recorded; in stop mode qualifying commits are counted in dropped. circ_mode changes take effect immediately.
- Pointer wrap-around uses DEPTH as a power of 2; count ranges 0..DEPTH inclusive.

Test Plan:
- Reset, then arm with trig_en=0, circ_mode=0, filter_we=0; retire 3 commits on consecutive cycles (pc 0x00400000/04/08) -> count=3, state CAPTURE, records pop in order with ts=0,1,2 and the matching pc/inst.
- trig_en=1, trig_pc=0x0040000C, commits at pc 0x00400000..0x00400010 -> only 0x0040000C (ts=0) and 0x00400010 (ts=1) recorded; state 01 until the trigger, then 10.
- DEPTH=4, stop mode, 6 qualifying commits, rd_ready=0 -> count=4, state DONE after the 4th, dropped=2, first pop returns the 1st commit.
- DEPTH=4, circular, 6 commits, rd_ready=0 -> count=4, overflow=1, pops return commits 3..6. Then push+pop in the same cycle while full -> count stays 4, overflow unchanged.
- filter_we=1, commits with (we=0), (we=1, waddr=0), (we=1, waddr=8, wdata=0x1234) -> only the last is recorded, count=1.
- During CAPTURE with count=2: assert reset -> state 00, count 0, rd_valid 0, dropped 0. Separately, arm during DONE -> buffer cleared, state 10 or 01 per trig_en.
